// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the iterative 8-by-4 restoring divider.
package restoring_divider_pkg;

  localparam int DW = 8;                // dividend / quotient width
  localparam int VW = 4;                // divisor / remainder width
  localparam int CW = $clog2(DW + 1);   // iteration counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface restoring_divider_if;
  import restoring_divider_pkg::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  // Requester side: issues operations and receives results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_sub_stage.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor and keep the difference only if it is non-negative.
module div_sub_stage
  import restoring_divider_pkg::*;
(
  input  logic [VW-1:0] partial_rem,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0] trial;
  logic [VW:0] diff;

  // partial_rem < divisor keeps trial below 2*divisor, so VW+1 bits suffice
  // and the reduced remainder always fits back into VW bits.
  always_comb begin
    trial = {partial_rem, bit_in};
    diff  = trial - {1'b0, divisor};
    q_bit = (trial >= {1'b0, divisor});
    if (q_bit) begin
      rem_out = diff[VW-1:0];
    end else begin
      rem_out = trial[VW-1:0];
    end
  end

endmodule

// File: rtl/restoring_divider_8by4.sv
// Iterative restoring divider: one quotient bit per clock, MSB first,
// with a start/busy/done handshake and registered results.
module restoring_divider_8by4
  import restoring_divider_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  restoring_divider_if.slave bus
);

  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [DW-1:0] dividend_reg;   // shifts left; MSB feeds the next iteration
  logic [VW-1:0] divisor_reg;
  logic [VW-1:0] prem_reg;       // running partial remainder
  logic [DW-2:0] quot_reg;       // quotient bits gathered so far
  logic [DW-1:0] quotient_reg;
  logic [VW-1:0] remainder_reg;
  logic          dbz_reg;

  logic [VW-1:0] rem_out;
  logic          q_bit;
  logic          accept;
  logic          zero_div;
  logic          last_iter;

  assign accept    = (state_reg == IDLE) && bus.start;
  assign zero_div  = (bus.divisor == '0);
  assign last_iter = (state_reg == RUN) && (count_reg == LAST_ITER);

  div_sub_stage u_stage (
    .partial_rem (prem_reg),
    .bit_in      (dividend_reg[DW-1]),
    .divisor     (divisor_reg),
    .rem_out     (rem_out),
    .q_bit       (q_bit)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: zero divisor skips straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-edge iteration, and result registers
  // that only change when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      prem_reg      <= '0;
      quot_reg      <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient_reg  <= '1;
        remainder_reg <= '0;
        dbz_reg       <= 1'b1;
      end else begin
        dividend_reg <= bus.dividend;
        divisor_reg  <= bus.divisor;
        count_reg    <= '0;
        prem_reg     <= '0;
        quot_reg     <= '0;
      end
    end else if (state_reg == RUN) begin
      dividend_reg <= {dividend_reg[DW-2:0], 1'b0};
      prem_reg     <= rem_out;
      quot_reg     <= {quot_reg[DW-3:0], q_bit};
      count_reg    <= count_reg + 1'b1;
      if (last_iter) begin
        quotient_reg  <= {quot_reg, q_bit};
        remainder_reg <= rem_out;
        dbz_reg       <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = (state_reg == DONE);
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
